wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter
// ----------
// Round-robin writeback arbiter for N_REQ functional units sharing one
// register-file write port. It also tracks how many issued instructions are
// still in flight, and it can flush them. A flush keeps accepting results
// until every in-flight instruction has retired, but it suppresses their
// register-file writes.
//
// Handshakes (valid/ready): a transfer happens only in a cycle where both
// sides are high. issue_valid without issue_ready is ignored. A result is
// retired in the cycle where req_valid[i] && req_grant[i]. The arbiter
// never waits on the requester after it grants.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   issue_valid/ready     one instruction issued per accepted cycle
//   flush                 single-cycle pulse, discards in-flight results
//   req_valid/addr/data   per-unit pending result (packed, unit 0 at LSBs)
//   req_grant             one-hot grant (combinational)
//   wb_en/addr/data       registered register-file write (1-cycle latency)
//   disable_wb            high while flushing (or recovering from a bad state)
//   pipe_empty            nothing in flight and no write pending
module wb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int MAX_OUT = 7
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_grant,
    output logic                    wb_en,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    disable_wb,
    output logic                    pipe_empty
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_OUT + 1);

    // Two spare encodings exist. They fall through to the recovery branch.
    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_FLUSH = 2'b01
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   outstanding, out_nxt;
    logic [PW-1:0]   rr_ptr, rr_nxt, grant_idx, idx;
    logic [PW:0]     sum;
    logic            any_grant, issue_acc, wb_allow;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Round-robin search: start at rr_ptr, walk upward, wrap at N_REQ-1.
    always_comb begin
        req_grant = '0;
        any_grant = 1'b0;
        grant_idx = '0;
        sel_addr  = '0;
        sel_data  = '0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
            idx = sum[PW-1:0];
            if (!any_grant && req_valid[idx]) begin
                any_grant      = 1'b1;
                req_grant[idx] = 1'b1;
                grant_idx      = idx;
                sel_addr       = req_addr[idx*ADDR_W +: ADDR_W];
                sel_data       = req_data[idx*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_nxt = (grant_idx == PW'(N_REQ - 1)) ? '0 : grant_idx + PW'(1);

    // Issue is only accepted in S_RUN with capacity left.
    assign issue_ready = (state == S_RUN) && (outstanding < CW'(MAX_OUT));
    assign issue_acc   = issue_valid && issue_ready;

    // A grant with nothing outstanding is a protocol error. The count
    // saturates at zero instead of wrapping.
    always_comb begin
        out_nxt = outstanding;
        if (issue_acc && !any_grant)
            out_nxt = outstanding + CW'(1);
        else if (!issue_acc && any_grant && outstanding != '0)
            out_nxt = outstanding - CW'(1);
    end

    always_comb begin
        state_nxt  = state;
        disable_wb = 1'b0;
        wb_allow   = 1'b0;
        case (state)
            S_RUN: begin
                // A grant in the same cycle as flush is treated as flushed.
                wb_allow = !flush;
                if (flush && !(outstanding == '0 && !issue_acc))
                    state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                disable_wb = 1'b1;
                if (out_nxt == '0)
                    state_nxt = S_RUN;
            end
            default: begin
                disable_wb = 1'b1;
                state_nxt  = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_RUN;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
            rr_ptr      <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
        end else begin
            outstanding <= out_nxt;
            if (any_grant) rr_ptr <= rr_nxt;
            wb_en <= any_grant && wb_allow;
            // Address/data hold their last written value when no write occurs.
            if (any_grant && wb_allow) begin
                wb_addr <= sel_addr;
                wb_data <= sel_data;
            end
        end
    end

    assign pipe_empty = (outstanding == '0) && !wb_en;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        issue_valid;
  logic        issue_ready;
  logic        flush;
  logic [3:0]  req_valid;
  logic [19:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  req_grant;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        disable_wb;
  logic        pipe_empty;

  int n_cmp = 0;
  int n_err = 0;

  wb_arbiter #(.N_REQ(4), .DATA_W(32), .ADDR_W(5), .MAX_OUT(7)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_grant   (req_grant),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .disable_wb  (disable_wb),
    .pipe_empty  (pipe_empty)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b1;
    issue_valid = 1'b0;
    flush       = 1'b0;
    req_valid   = 4'b0000;
    // unit i writes register 10+i with data DDDD_000i
    req_addr = {5'd13, 5'd12, 5'd11, 5'd10};
    req_data = {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'hDDDD_0000};

    // reset values
    #1 reset_n = 1'b0;
    #2;
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_disable_wb", disable_wb, 0);
    chk("rst_pipe_empty", pipe_empty, 1);
    chk("rst_wb_en", wb_en, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // round robin: 3 issues, req_valid 1011 -> grants 0,1,3
    issue_valid = 1'b1;
    repeat (3) tick();
    issue_valid = 1'b0;
    chk("rr_out3", dut.outstanding, 3);
    chk("rr_not_empty", pipe_empty, 0);
    req_valid = 4'b1011;
    #1;
    chk("rr_grant0", req_grant, 4'b0001);
    tick();
    chk("rr_wb0_en", wb_en, 1);
    chk("rr_wb0_addr", wb_addr, 10);
    chk("rr_wb0_data", wb_data, 32'hDDDD_0000);
    chk("rr_grant1", req_grant, 4'b0010);
    tick();
    chk("rr_wb1_en", wb_en, 1);
    chk("rr_wb1_addr", wb_addr, 11);
    chk("rr_wb1_data", wb_data, 32'hDDDD_0001);
    chk("rr_grant3", req_grant, 4'b1000);
    tick();
    req_valid = 4'b0000;
    chk("rr_wb3_en", wb_en, 1);
    chk("rr_wb3_addr", wb_addr, 13);
    chk("rr_wb3_data", wb_data, 32'hDDDD_0003);
    chk("rr_out0", dut.outstanding, 0);
    chk("rr_pending_not_empty", pipe_empty, 0);
    tick();
    chk("rr_idle_wb_en", wb_en, 0);
    chk("rr_idle_empty", pipe_empty, 1);
    chk("rr_hold_addr", wb_addr, 13);
    chk("rr_hold_data", wb_data, 32'hDDDD_0003);

    // capacity: 7 issues fill, 8th ignored
    issue_valid = 1'b1;
    repeat (7) tick();
    chk("cap_full_ready", issue_ready, 0);
    chk("cap_full_out", dut.outstanding, 7);
    tick();
    chk("cap_8th_ignored", dut.outstanding, 7);
    chk("cap_still_full", issue_ready, 0);
    // grant while full: the issue is ignored (ready low), so the count drops
    req_valid = 4'b0001;
    #1;
    chk("cap_grant", req_grant, 4'b0001);
    tick();
    chk("cap_grant_full_out", dut.outstanding, 6);
    chk("cap_ready_again", issue_ready, 1);
    chk("cap_wb_addr", wb_addr, 10);
    // grant plus accepted issue: count unchanged
    tick();
    chk("cap_both_out", dut.outstanding, 6);
    chk("cap_both_ready", issue_ready, 1);
    req_valid = 4'b0000;
    tick();
    issue_valid = 1'b0;
    chk("cap_refill_out", dut.outstanding, 7);
    chk("cap_refill_ready", issue_ready, 0);
    // drain from rr_ptr 1: units 1,2,3,0,1,2,3
    req_valid = 4'b1111;
    repeat (7) tick();
    req_valid = 4'b0000;
    chk("drain_out", dut.outstanding, 0);
    chk("drain_last_addr", wb_addr, 13);
    chk("drain_rr", dut.rr_ptr, 0);
    tick();
    chk("drain_empty", pipe_empty, 1);

    // flush: 3 outstanding, flush pulse, then 3 silent grants
    issue_valid = 1'b1;
    repeat (3) tick();
    issue_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_disable", disable_wb, 1);
    chk("fl_ready_off", issue_ready, 0);
    req_valid = 4'b0111;
    #1;
    chk("fl_grant0", req_grant, 4'b0001);
    tick();
    chk("fl_wb0_off", wb_en, 0);
    chk("fl_disable_1", disable_wb, 1);
    chk("fl_grant1", req_grant, 4'b0010);
    tick();
    chk("fl_wb1_off", wb_en, 0);
    chk("fl_disable_2", disable_wb, 1);
    chk("fl_grant2", req_grant, 4'b0100);
    tick();
    req_valid = 4'b0000;
    chk("fl_wb2_off", wb_en, 0);
    chk("fl_back_run", disable_wb, 0);
    chk("fl_ready_on", issue_ready, 1);
    chk("fl_empty", pipe_empty, 1);
    chk("fl_hold_addr", wb_addr, 13);

    // flush in the same cycle as a grant of unit 2 (rr_ptr is 3)
    issue_valid = 1'b1;
    repeat (3) tick();
    issue_valid = 1'b0;
    req_valid = 4'b0100;
    flush = 1'b1;
    #1;
    chk("sim_grant2", req_grant, 4'b0100);
    tick();
    flush = 1'b0;
    req_valid = 4'b0000;
    chk("sim_no_write", wb_en, 0);
    chk("sim_rr3", dut.rr_ptr, 3);
    chk("sim_flushing", disable_wb, 1);
    chk("sim_out2", dut.outstanding, 2);
    chk("sim_hold_addr", wb_addr, 13);

    // reset mid-flush with 2 outstanding: async, same cycle
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_ready", issue_ready, 1);
    chk("mrst_disable", disable_wb, 0);
    chk("mrst_empty", pipe_empty, 1);
    chk("mrst_wb_en", wb_en, 0);
    chk("mrst_wb_addr", wb_addr, 0);
    chk("mrst_wb_data", wb_data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // first grant after reset starts at unit 0; underflow saturates
    req_valid = 4'b1111;
    #1;
    chk("uf_grant0", req_grant, 4'b0001);
    tick();
    req_valid = 4'b0000;
    chk("uf_wb_en", wb_en, 1);
    chk("uf_wb_addr", wb_addr, 10);
    chk("uf_wb_data", wb_data, 32'hDDDD_0000);
    chk("uf_out0", dut.outstanding, 0);
    chk("uf_not_empty", pipe_empty, 0);
    chk("uf_ready", issue_ready, 1);
    tick();
    chk("uf_empty", pipe_empty, 1);
    chk("uf_wb_off", wb_en, 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
